// File: rtl/fifo_pkg.sv
// Shared FIFO constants, read-mode enum and pointer wrap helper.
// Imported by the pointer controller, the FIFO top and its interface users.
package fifo_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_DEPTH      = 3;

    typedef enum logic {
        READ_REG  = 1'b0,
        READ_FWFT = 1'b1
    } read_mode_e;

    // Wrap by explicit compare so non-power-of-2 depths work.
    function automatic int next_ptr(input int ptr, input int depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_ctrl_if.sv
// Producer/consumer bundle for sync_fifo_ctrl.
// master: drives wr_data/wr_en/rd_en/clr_err; slave: the FIFO, drives status and read data.
interface sync_fifo_ctrl_if #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 2
);
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_en;
    logic                  rd_en;
    logic                  clr_err;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [CNT_WIDTH-1:0]  count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output wr_data, wr_en, rd_en, clr_err,
        input  rd_data, rd_valid, full, empty,
        input  almost_full, almost_empty, count,
        input  overflow, underflow
    );

    modport slave (
        input  wr_data, wr_en, rd_en, clr_err,
        output rd_data, rd_valid, full, empty,
        output almost_full, almost_empty, count,
        output overflow, underflow
    );
endinterface

// File: rtl/fifo_ptr_ctrl.sv
// Pointer, occupancy and flag control for sync_fifo_ctrl.
// Ports: clk, rst, wr_en/rd_en in; accept strobes, pointers, count, flags out.
module fifo_ptr_ctrl
    import fifo_pkg::*;
#(
    parameter int DEPTH      = DEF_DEPTH,
    parameter int AF_LEVEL   = DEPTH - 1,
    parameter int AE_LEVEL   = 1,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic                  rd_en,
    output logic                  wr_accept,
    output logic                  rd_accept,
    output logic [ADDR_WIDTH-1:0] wr_ptr,
    output logic [ADDR_WIDTH-1:0] rd_ptr,
    output logic [CNT_WIDTH-1:0]  count,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty
);

    assign full         = (count == CNT_WIDTH'(DEPTH));
    assign empty        = (count == '0);
    assign almost_full  = (int'(count) >= AF_LEVEL);
    assign almost_empty = (int'(count) <= AE_LEVEL);

    // A read on a full FIFO frees the slot for a same-cycle write;
    // a write into an empty FIFO never rescues a same-cycle read.
    assign rd_accept = rd_en && !empty;
    assign wr_accept = wr_en && (!full || rd_accept);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_accept)
                wr_ptr <= ADDR_WIDTH'(next_ptr(int'(wr_ptr), DEPTH));
            if (rd_accept)
                rd_ptr <= ADDR_WIDTH'(next_ptr(int'(rd_ptr), DEPTH));
            case ({wr_accept, rd_accept})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO: storage, read-data path (registered or FWFT) and sticky errors.
// Ports: clk, rst (sync, active-high), bus (sync_fifo_ctrl_if.slave).
module sync_fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int         DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int         DEPTH      = DEF_DEPTH,
    parameter int         AF_LEVEL   = DEPTH - 1,
    parameter int         AE_LEVEL   = 1,
    parameter read_mode_e FWFT       = READ_REG,
    parameter int         ADDR_WIDTH = $clog2(DEPTH),
    parameter int         CNT_WIDTH  = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    sync_fifo_ctrl_if.slave  bus
);

    logic                  wr_accept;
    logic                  rd_accept;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [CNT_WIDTH-1:0]  count;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic                  overflow;
    logic                  underflow;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    fifo_ptr_ctrl #(
        .DEPTH      (DEPTH),
        .AF_LEVEL   (AF_LEVEL),
        .AE_LEVEL   (AE_LEVEL),
        .ADDR_WIDTH (ADDR_WIDTH),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_ptr (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (bus.wr_en),
        .rd_en        (bus.rd_en),
        .wr_accept    (wr_accept),
        .rd_accept    (rd_accept),
        .wr_ptr       (wr_ptr),
        .rd_ptr       (rd_ptr),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty)
    );

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_accept)
            mem[wr_ptr] <= bus.wr_data;
    end

    // Set wins over clear when both happen in one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= (bus.wr_en && !wr_accept) || (overflow && !bus.clr_err);
            underflow <= (bus.rd_en && !rd_accept) || (underflow && !bus.clr_err);
        end
    end

    generate
        if (FWFT == READ_FWFT) begin : g_fwft
            assign bus.rd_data  = empty ? '0 : mem[rd_ptr];
            assign bus.rd_valid = !empty;
        end else begin : g_reg
            logic [DATA_WIDTH-1:0] rd_data_q;
            logic                  rd_valid_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    rd_data_q  <= '0;
                    rd_valid_q <= 1'b0;
                end else begin
                    rd_valid_q <= rd_accept;
                    if (rd_accept)
                        rd_data_q <= mem[rd_ptr];
                end
            end

            assign bus.rd_data  = rd_data_q;
            assign bus.rd_valid = rd_valid_q;
        end
    endgenerate

    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.almost_full  = almost_full;
    assign bus.almost_empty = almost_empty;
    assign bus.count        = count;
    assign bus.overflow     = overflow;
    assign bus.underflow    = underflow;

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Bench for sync_fifo_ctrl: DEPTH=3 registered-read and DEPTH=5 FWFT instances
// checked against queue-based reference models under directed and random traffic.
module tb_sync_fifo_ctrl;
    import fifo_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    sync_fifo_ctrl_if #(.DATA_WIDTH(32), .CNT_WIDTH(2)) bus_a();
    sync_fifo_ctrl_if #(.DATA_WIDTH(32), .CNT_WIDTH(3)) bus_b();

    sync_fifo_ctrl #(
        .DATA_WIDTH(32), .DEPTH(3), .AF_LEVEL(2), .AE_LEVEL(1), .FWFT(READ_REG)
    ) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    sync_fifo_ctrl #(
        .DATA_WIDTH(32), .DEPTH(5), .AF_LEVEL(4), .AE_LEVEL(1), .FWFT(READ_FWFT)
    ) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    logic [31:0] qa[$];
    logic [31:0] qb[$];
    bit          ova, una, ovb, unb, rva;
    logic [31:0] rda;

    task automatic clear_inputs();
        bus_a.wr_en = 0; bus_a.rd_en = 0; bus_a.clr_err = 0; bus_a.wr_data = '0;
        bus_b.wr_en = 0; bus_b.rd_en = 0; bus_b.clr_err = 0; bus_b.wr_data = '0;
    endtask

    task automatic do_reset(input bit with_traffic);
        clear_inputs();
        if (with_traffic) begin
            bus_a.wr_en = 1; bus_a.rd_en = 1; bus_a.wr_data = 32'hDEAD;
            bus_b.wr_en = 1; bus_b.rd_en = 1; bus_b.wr_data = 32'hDEAD;
        end
        rst = 1;
        @(posedge clk);
        #1;
        rst = 0;
        clear_inputs();
        qa.delete(); qb.delete();
        ova = 0; una = 0; ovb = 0; unb = 0; rva = 0; rda = '0;
    endtask

    task automatic cyc_a(input bit we, input bit re, input bit clr, input logic [31:0] wd);
        bit rok, wok;
        bus_a.wr_en = we; bus_a.rd_en = re; bus_a.clr_err = clr; bus_a.wr_data = wd;
        @(posedge clk);
        rok = re && (qa.size() > 0);
        wok = we && (qa.size() < 3 || rok);
        rva = rok;
        if (rok) rda = qa.pop_front();
        if (wok) qa.push_back(wd);
        ova = (we && !wok) || (ova && !clr);
        una = (re && !rok) || (una && !clr);
        #1;
        clear_inputs();
    endtask

    task automatic cyc_b(input bit we, input bit re, input bit clr, input logic [31:0] wd);
        bit rok, wok;
        bus_b.wr_en = we; bus_b.rd_en = re; bus_b.clr_err = clr; bus_b.wr_data = wd;
        @(posedge clk);
        rok = re && (qb.size() > 0);
        wok = we && (qb.size() < 5 || rok);
        if (rok) void'(qb.pop_front());
        if (wok) qb.push_back(wd);
        ovb = (we && !wok) || (ovb && !clr);
        unb = (re && !rok) || (unb && !clr);
        #1;
        clear_inputs();
    endtask

    task automatic test_reset();
        do_reset(1);
        checks++;
        if ({bus_a.count, bus_a.empty, bus_a.full, bus_a.almost_empty, bus_a.almost_full} !== {2'd0, 4'b1010}) begin
            failures++;
            $display("FAIL reset_flags_a got cnt=%0d e=%b f=%b ae=%b af=%b exp cnt=0 e=1 f=0 ae=1 af=0",
                     bus_a.count, bus_a.empty, bus_a.full, bus_a.almost_empty, bus_a.almost_full);
        end
        checks++;
        if ({bus_a.rd_valid, bus_a.rd_data, bus_a.overflow, bus_a.underflow} !== 35'd0) begin
            failures++;
            $display("FAIL reset_data_a got v=%b d=%h ov=%b un=%b exp all 0",
                     bus_a.rd_valid, bus_a.rd_data, bus_a.overflow, bus_a.underflow);
        end
        checks++;
        if ({bus_b.count, bus_b.empty, bus_b.full, bus_b.almost_empty, bus_b.almost_full,
             bus_b.rd_valid, bus_b.rd_data} !== {3'd0, 4'b1010, 33'd0}) begin
            failures++;
            $display("FAIL reset_b got cnt=%0d e=%b f=%b ae=%b af=%b v=%b d=%h",
                     bus_b.count, bus_b.empty, bus_b.full, bus_b.almost_empty,
                     bus_b.almost_full, bus_b.rd_valid, bus_b.rd_data);
        end
    endtask

    task automatic test_fill_overflow();
        logic [31:0] exp;
        do_reset(0);
        for (int i = 0; i < 3; i++) cyc_a(1, 0, 0, 32'hA1 + i);
        checks++;
        if ({bus_a.full, bus_a.count} !== {1'b1, 2'd3}) begin
            failures++;
            $display("FAIL fill_full got f=%b cnt=%0d exp f=1 cnt=3", bus_a.full, bus_a.count);
        end
        cyc_a(1, 0, 0, 32'hA4);
        checks++;
        if ({bus_a.overflow, bus_a.count} !== {1'b1, 2'd3}) begin
            failures++;
            $display("FAIL overflow got ov=%b cnt=%0d exp ov=1 cnt=3", bus_a.overflow, bus_a.count);
        end
        for (int i = 0; i < 3; i++) begin
            exp = 32'hA1 + i;
            cyc_a(0, 1, 0, '0);
            checks++;
            if ({bus_a.rd_valid, bus_a.rd_data} !== {1'b1, exp}) begin
                failures++;
                $display("FAIL fill_read%0d got v=%b d=%h exp v=1 d=%h", i, bus_a.rd_valid, bus_a.rd_data, exp);
            end
        end
        cyc_a(0, 0, 0, '0);
        checks++;
        if ({bus_a.rd_valid, bus_a.rd_data, bus_a.empty} !== {1'b0, 32'hA3, 1'b1}) begin
            failures++;
            $display("FAIL read_hold got v=%b d=%h e=%b exp v=0 d=a3 e=1", bus_a.rd_valid, bus_a.rd_data, bus_a.empty);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] exp;
        do_reset(0);
        for (int i = 0; i < 7; i++) begin
            exp = 32'h10 + i;
            cyc_a(1, 0, 0, exp);
            cyc_a(0, 0, 0, '0);
            cyc_a(0, 1, 0, '0);
            checks++;
            if ({bus_a.rd_valid, bus_a.rd_data, bus_a.empty} !== {1'b1, exp, 1'b1}) begin
                failures++;
                $display("FAIL wrap%0d got v=%b d=%h e=%b exp v=1 d=%h e=1", i, bus_a.rd_valid, bus_a.rd_data, bus_a.empty, exp);
            end
        end
    endtask

    task automatic test_full_rw();
        logic [31:0] exp [4];
        exp[0] = 32'h1; exp[1] = 32'h2; exp[2] = 32'h3; exp[3] = 32'hBEEF;
        do_reset(0);
        for (int i = 0; i < 3; i++) cyc_a(1, 0, 0, exp[i]);
        cyc_a(1, 1, 0, 32'hBEEF);
        checks++;
        if ({bus_a.count, bus_a.overflow, bus_a.full, bus_a.rd_data} !== {2'd3, 1'b0, 1'b1, 32'h1}) begin
            failures++;
            $display("FAIL full_rw got cnt=%0d ov=%b f=%b d=%h exp cnt=3 ov=0 f=1 d=1",
                     bus_a.count, bus_a.overflow, bus_a.full, bus_a.rd_data);
        end
        for (int i = 1; i < 4; i++) begin
            cyc_a(0, 1, 0, '0);
            checks++;
            if ({bus_a.rd_valid, bus_a.rd_data} !== {1'b1, exp[i]}) begin
                failures++;
                $display("FAIL full_rw_read%0d got v=%b d=%h exp v=1 d=%h", i, bus_a.rd_valid, bus_a.rd_data, exp[i]);
            end
        end
    endtask

    task automatic test_empty_rw();
        do_reset(0);
        cyc_a(1, 1, 0, 32'h55);
        checks++;
        if ({bus_a.underflow, bus_a.count, bus_a.rd_valid} !== {1'b1, 2'd1, 1'b0}) begin
            failures++;
            $display("FAIL empty_rw got un=%b cnt=%0d v=%b exp un=1 cnt=1 v=0", bus_a.underflow, bus_a.count, bus_a.rd_valid);
        end
        cyc_a(0, 1, 0, '0);
        checks++;
        if ({bus_a.rd_valid, bus_a.rd_data} !== {1'b1, 32'h55}) begin
            failures++;
            $display("FAIL empty_rw_read got v=%b d=%h exp v=1 d=55", bus_a.rd_valid, bus_a.rd_data);
        end
        cyc_a(0, 0, 1, '0);
        checks++;
        if (bus_a.underflow !== 1'b0) begin
            failures++;
            $display("FAIL clr_underflow got un=%b exp 0", bus_a.underflow);
        end
    endtask

    task automatic test_fwft();
        do_reset(0);
        cyc_b(1, 0, 0, 32'hAA);
        checks++;
        if ({bus_b.rd_valid, bus_b.rd_data} !== {1'b1, 32'hAA}) begin
            failures++;
            $display("FAIL fwft_show got v=%b d=%h exp v=1 d=aa", bus_b.rd_valid, bus_b.rd_data);
        end
        cyc_b(0, 1, 0, '0);
        checks++;
        if ({bus_b.empty, bus_b.rd_valid, bus_b.rd_data} !== {1'b1, 1'b0, 32'h0}) begin
            failures++;
            $display("FAIL fwft_pop got e=%b v=%b d=%h exp e=1 v=0 d=0", bus_b.empty, bus_b.rd_valid, bus_b.rd_data);
        end
    endtask

    task automatic test_thresholds();
        do_reset(0);
        for (int i = 1; i <= 4; i++) begin
            cyc_b(1, 0, 0, $urandom);
            checks++;
            if ({bus_b.almost_full, bus_b.almost_empty} !== {i >= 4, i <= 1}) begin
                failures++;
                $display("FAIL thresh_cnt%0d got af=%b ae=%b exp af=%b ae=%b",
                         i, bus_b.almost_full, bus_b.almost_empty, i >= 4, i <= 1);
            end
        end
        do_reset(1);
        checks++;
        if ({bus_b.count, bus_b.empty, bus_b.almost_full, bus_b.almost_empty, bus_b.overflow} !== {3'd0, 4'b1010}) begin
            failures++;
            $display("FAIL rst_midway got cnt=%0d e=%b af=%b ae=%b ov=%b exp cnt=0 e=1 af=0 ae=1 ov=0",
                     bus_b.count, bus_b.empty, bus_b.almost_full, bus_b.almost_empty, bus_b.overflow);
        end
        for (int i = 0; i < 6; i++) cyc_b(1, 0, 0, $urandom);
        cyc_b(1, 0, 1, 32'h77);
        checks++;
        if ({bus_b.overflow, bus_b.full} !== 2'b11) begin
            failures++;
            $display("FAIL clr_vs_set got ov=%b f=%b exp ov=1 f=1", bus_b.overflow, bus_b.full);
        end
        cyc_b(0, 0, 1, '0);
        checks++;
        if (bus_b.overflow !== 1'b0) begin
            failures++;
            $display("FAIL clr_overflow got ov=%b exp 0", bus_b.overflow);
        end
    endtask

    task automatic test_random();
        bit we, re, clr;
        do_reset(0);
        for (int i = 0; i < 400; i++) begin
            we  = ((i / 40) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            re  = ((i / 40) % 2 == 1) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            clr = ($urandom_range(0, 15) == 0);
            cyc_a(we, re, clr, $urandom);
            checks++;
            if ({bus_a.count, bus_a.full, bus_a.empty, bus_a.almost_full, bus_a.almost_empty} !==
                {2'(qa.size()), qa.size() == 3, qa.size() == 0, qa.size() >= 2, qa.size() <= 1}) begin
                failures++;
                $display("FAIL rand_a_state cyc=%0d got cnt=%0d f=%b e=%b af=%b ae=%b exp cnt=%0d",
                         i, bus_a.count, bus_a.full, bus_a.empty, bus_a.almost_full, bus_a.almost_empty, qa.size());
            end
            checks++;
            if ({bus_a.rd_valid, bus_a.rd_data, bus_a.overflow, bus_a.underflow} !== {rva, rda, ova, una}) begin
                failures++;
                $display("FAIL rand_a_data cyc=%0d got v=%b d=%h ov=%b un=%b exp v=%b d=%h ov=%b un=%b",
                         i, bus_a.rd_valid, bus_a.rd_data, bus_a.overflow, bus_a.underflow, rva, rda, ova, una);
            end
        end
        for (int i = 0; i < 400; i++) begin
            we  = ((i / 50) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            re  = ((i / 50) % 2 == 1) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            clr = ($urandom_range(0, 15) == 0);
            cyc_b(we, re, clr, $urandom);
            checks++;
            if ({bus_b.count, bus_b.full, bus_b.empty, bus_b.almost_full, bus_b.almost_empty} !==
                {3'(qb.size()), qb.size() == 5, qb.size() == 0, qb.size() >= 4, qb.size() <= 1}) begin
                failures++;
                $display("FAIL rand_b_state cyc=%0d got cnt=%0d f=%b e=%b af=%b ae=%b exp cnt=%0d",
                         i, bus_b.count, bus_b.full, bus_b.empty, bus_b.almost_full, bus_b.almost_empty, qb.size());
            end
            checks++;
            if ({bus_b.rd_valid, bus_b.rd_data, bus_b.overflow, bus_b.underflow} !==
                {qb.size() > 0, (qb.size() > 0) ? qb[0] : 32'h0, ovb, unb}) begin
                failures++;
                $display("FAIL rand_b_data cyc=%0d got v=%b d=%h ov=%b un=%b exp v=%b ov=%b un=%b",
                         i, bus_b.rd_valid, bus_b.rd_data, bus_b.overflow, bus_b.underflow, qb.size() > 0, ovb, unb);
            end
        end
    endtask

    initial begin
        clear_inputs();
        #2;
        test_reset();
        test_fill_overflow();
        test_wrap();
        test_full_rw();
        test_empty_rw();
        test_fwft();
        test_thresholds();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sync_fifo_ctrl.md
Name: sync_fifo_ctrl

Overview:
- Synchronous single-clock FIFO; second-generation buffer for the data-path staging points.
- Adds: arbitrary non-power-of-2 depth, full/empty/almost flags, occupancy count, simultaneous read+write, selectable read mode (registered 1-cycle or first-word-fall-through), sticky overflow/underflow error flags.
- Sits between producer and consumer blocks that exchange data through wr_en/rd_en strobes.

Parameters:
- DATA_WIDTH, 32, width of the data word.
- DEPTH, 3, number of entries; any integer >= 2, not restricted to powers of two.
- AF_LEVEL, DEPTH-1, almost_full asserts when count >= AF_LEVEL.
- AE_LEVEL, 1, almost_empty asserts when count <= AE_LEVEL.
- FWFT, 0, read mode: 0 = registered read with 1-cycle latency; 1 = head word shown combinationally while not empty.
- ADDR_WIDTH, $clog2(DEPTH), pointer width (derived).
- CNT_WIDTH, $clog2(DEPTH+1), count width (derived).

Ports:
- clk  in  1  clock, all logic on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- wr_data  in  DATA_WIDTH  write word.
- wr_en  in  1  push strobe.
- rd_en  in  1  pop strobe.
- clr_err  in  1  clears the sticky error flags.
- rd_data  out  DATA_WIDTH  read word.
- rd_valid  out  1  rd_data is meaningful this cycle.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_LEVEL.
- almost_empty  out  1  count <= AE_LEVEL.
- count  out  CNT_WIDTH  current occupancy.
- overflow  out  1  sticky: a write was dropped.
- underflow  out  1  sticky: a read was refused.

Behaviour:
- Reset: reset is synchronous, active-high, on rst; clock is clk.
  - Pointers = 0, count = 0, empty = 1, full = 0, almost_empty = 1, almost_full = (AF_LEVEL == 0).
  - rd_data = 0, rd_valid = 0, overflow = 0, underflow = 0.
  - Storage array is not reset.
  - rst overrides all other inputs in the same cycle, including mid-operation; contents are discarded.
- Pointers:
  - Write pointer and read pointer each increment by 1 on an accepted operation.
  - At DEPTH-1 a pointer wraps to 0 (explicit compare, never modulo-2^n).
- Write acceptance: wr_en && (!full || rd_accept). When full, a simultaneous accepted read frees a slot in the same cycle.
- Read acceptance: rd_en && !empty. When empty, a simultaneous write does NOT make the read succeed; the write is accepted and the read is refused.
- Count update: +1 on write only; -1 on read only; unchanged when both are accepted or neither is.
- Flags are derived from the registered count and are valid in the cycle after the update.
- Overflow: set on wr_en && !write_accept; held until clr_err or rst.
- Underflow: set on rd_en && !read_accept; held until clr_err or rst.
- If clr_err and a new error event occur in the same cycle, the flag stays set (set wins).
- Refused operations never change pointers, count or storage.
- FWFT=0 mode:
  - An accepted read registers mem[rd_ptr] into rd_data on that edge.
  - rd_valid pulses high for exactly the following cycle.
  - rd_data holds its last value otherwise.
  - Read latency is 1 cycle.
- FWFT=1 mode:
  - rd_data = mem[rd_ptr] when !empty, else 0. rd_valid = !empty.
  - rd_en pops the word shown this cycle.
  - Write-to-visible latency is 1 cycle: a word written into an empty FIFO appears the cycle after its wr_en.
- No bypass path: data is never forwarded from wr_data to rd_data in the same cycle.
- DEPTH=2 edge case: pointer wrap and full/empty behave identically to larger depths.

Decomposition:
- Shared package fifo_pkg holds:
  - default DATA_WIDTH and DEPTH constants;
  - a function next_ptr(ptr, depth) implementing the wrap compare;
  - an enum of read modes (READ_REG = 0, READ_FWFT = 1) used for the FWFT parameter.
- One natural sub-module: fifo_ptr_ctrl.
  - Contains the pointers, count, flags and acceptance logic.
  - sync_fifo_ctrl adds the storage array, read-data path and error flags.

Test Plan:
- DEPTH=3, FWFT=0: write A1, A2, A3 -> full=1 and count=3 after the 3rd write. A 4th write of A4 -> overflow=1, count stays 3. Reads return A1, A2, A3, each with rd_valid one cycle after rd_en.
- DEPTH=3: 7 write/read pairs spaced apart -> pointers wrap 0→1→2→0. Data order is preserved across the wrap (check values 0x10..0x16).
- Full FIFO, wr_en and rd_en together with wr_data=0xBEEF -> count stays 3, no overflow, 0xBEEF is read last.
- Empty FIFO, wr_en and rd_en together -> underflow=1, count=1. The next read returns the written word.
- FWFT=1, DEPTH=5: write 0xAA into empty -> rd_valid=1 and rd_data=0xAA the next cycle. rd_en pops it -> empty=1, rd_data=0.
- Thresholds AF_LEVEL=4, AE_LEVEL=1, DEPTH=5:
  - fill to 4 -> almost_full rises exactly at count=4;
  - assert rst with 4 entries -> next cycle count=0, empty=1, flags cleared;
  - clr_err pulsed during overflow -> overflow remains 1.
